// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - state encoding and sizing helpers for uart_frame_decoder
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_PREAMBLE_BYTE = 8'hFF;

    function automatic int frame_bytes(input int num_fields, input int field_bytes);
        return num_fields * field_bytes;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap watchdog; expired fires on the TIMEOUT_CYCLES-th idle cycle
module uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = &{1'b0, clk, rst_n, enable, kick};
        assign expired       = 1'b0;
    end else begin : g_on
        localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             hit;

        // A byte in the same cycle as the deadline wins: kick masks expiry.
        assign hit     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        assign expired = enable && !kick && hit;

        always_comb begin
            cnt_d = cnt_q + 1'b1;
            if (!enable || kick || hit) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - preamble-synced UART frame decoder with atomic field commit
// Optional trailing XOR checksum byte: define UART_FRAME_CHECKSUM_EN.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         NUM_FIELDS     = 2,
    parameter int         FIELD_BYTES    = 2,
    parameter logic [7:0] PREAMBLE_BYTE  = DEFAULT_PREAMBLE_BYTE,
    parameter int         PREAMBLE_LEN   = 4,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rx_done,
    input  logic [7:0]                          rx_data,
    output logic [NUM_FIELDS*FIELD_BYTES*8-1:0] fields,
    output logic                                frame_valid,
    output logic                                frame_err,
    output logic [7:0]                          frame_cnt,
    output logic [7:0]                          err_cnt
);

    localparam int FRAME_BYTES = frame_bytes(NUM_FIELDS, FIELD_BYTES);
    localparam int FRAME_BITS  = FRAME_BYTES * 8;
    localparam int IDX_W       = idx_width(FRAME_BYTES);
    localparam int SYNC_W      = idx_width(PREAMBLE_LEN);

    state_e                  state_q, state_d;
    logic [SYNC_W-1:0]       sync_cnt_q, sync_cnt_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
    logic [FRAME_BITS-1:0]   fields_q, fields_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    commit;
    logic                    abort;
    logic                    expired;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]              xor_q, xor_d;
`endif

    uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state_q != ST_HUNT),
        .kick   (rx_done),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        byte_idx_d = byte_idx_q;
        shadow_d   = shadow_q;
        commit     = 1'b0;
        abort      = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            ST_HUNT: begin
`ifdef UART_FRAME_CHECKSUM_EN
                xor_d = '0;
`endif
                if (rx_done) begin
                    if (rx_data != PREAMBLE_BYTE) begin
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q == SYNC_W'(PREAMBLE_LEN - 1)) begin
                        state_d    = ST_PAYLOAD;
                        sync_cnt_d = '0;
                        byte_idx_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    // Byte i lands at bits [i*8 +: 8], which is field i/FIELD_BYTES, lane i%FIELD_BYTES.
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        if (byte_idx_q == IDX_W'(i)) begin
                            shadow_d[i*8 +: 8] = rx_data;
                        end
                    end
                    byte_idx_d = byte_idx_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    if (byte_idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        byte_idx_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        commit = 1'b1;
`endif
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_done) begin
                    commit = (rx_data == xor_q);
                    abort  = (rx_data != xor_q);
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
`endif
            default: state_d = ST_HUNT;
        endcase

        if (commit || abort) begin
            state_d    = ST_HUNT;
            sync_cnt_d = '0;
            byte_idx_d = '0;
        end

        fields_d      = commit ? shadow_d : fields_q;
        frame_valid_d = commit;
        frame_err_d   = abort;
        frame_cnt_d   = frame_cnt_q + {7'd0, commit};
        err_cnt_d     = (abort && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            sync_cnt_q    <= '0;
            byte_idx_q    <= '0;
            shadow_q      <= '0;
            fields_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            xor_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            byte_idx_q    <= byte_idx_d;
            shadow_q      <= shadow_d;
            fields_q      <= fields_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
`ifdef UART_FRAME_CHECKSUM_EN
            xor_q         <= xor_d;
`endif
        end
    end

    assign fields      = fields_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - directed and randomized checks of uart_frame_decoder against a byte-level model
module tb_uart_frame_decoder;

    localparam int NF          = 2;
    localparam int FB          = 2;
    localparam int FRAME_BYTES = NF * FB;
    localparam int PL          = 4;
    localparam int TO          = 50;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] fields;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;

    int passed = 0;
    int total  = 0;

    bit          obs_err[$];
    logic [31:0] obs_fields[$];
    bit          exp_err[$];
    logic [31:0] exp_fields[$];
    logic [31:0] model_fields;
    int          exp_fc;
    int          exp_ec;

    uart_frame_decoder #(
        .NUM_FIELDS    (NF),
        .FIELD_BYTES   (FB),
        .PREAMBLE_BYTE (8'hFF),
        .PREAMBLE_LEN  (PL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .fields     (fields),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) begin
            obs_err.push_back(1'b0);
            obs_fields.push_back(fields);
        end
        if (frame_err) begin
            obs_err.push_back(1'b1);
            obs_fields.push_back(fields);
        end
    end

    // All drivers leave time parked 1 unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_rep(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b, 0);
    endtask

    task automatic send_payload4(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3, input int last_gap);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
        send_byte(b3, last_gap);
        if (CK != 0) send_byte(b0 ^ b1 ^ b2 ^ b3, 0);
    endtask

    task automatic clear_obs();
        obs_err.delete();
        obs_fields.delete();
    endtask

    task automatic model_commit(input logic [31:0] v);
        exp_err.push_back(1'b0);
        exp_fields.push_back(v);
        model_fields = v;
        exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic model_abort();
        exp_err.push_back(1'b1);
        exp_fields.push_back(model_fields);
        exp_ec = (exp_ec >= 255) ? 255 : exp_ec + 1;
    endtask

    // Byte-stream parser: gaps[i] idle cycles precede bytes[i]; tail idle cycles follow the last byte.
    task automatic model_stream(input logic [7:0] bytes[$], input int gaps[$], input int tail);
        int          run;
        bit          in_frame;
        logic [7:0]  pay[$];
        logic [7:0]  x;
        logic [31:0] v;
        run = 0;
        in_frame = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            if (in_frame && gaps[i] >= TO) begin
                model_abort();
                in_frame = 1'b0;
                run = 0;
            end
            if (!in_frame) begin
                run = (bytes[i] == 8'hFF) ? run + 1 : 0;
                if (run == PL) begin
                    in_frame = 1'b1;
                    pay.delete();
                end
            end else begin
                pay.push_back(bytes[i]);
                if (pay.size() == FRAME_BYTES + CK) begin
                    x = 8'h00;
                    v = 32'h0;
                    for (int k = 0; k < FRAME_BYTES; k++) begin
                        x = x ^ pay[k];
                        v = v + (32'(pay[k]) << (8 * k));
                    end
                    if (CK != 0 && pay[FRAME_BYTES] != x) model_abort();
                    else model_commit(v);
                    in_frame = 1'b0;
                    run = 0;
                end
            end
        end
        if (in_frame && tail >= TO) model_abort();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (fields !== 32'h0) $display("FAIL reset_fields got=%h exp=0", fields); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", frame_valid); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", frame_err); else passed++;
        total++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); else passed++;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        clear_obs();
        send_rep(8'hFF, 4);
        send_payload4(8'h34, 8'h12, 8'h78, 8'h56, 0);
        total++; if (frame_valid !== 1'b1) $display("FAIL basic_pulse got=%b exp=1", frame_valid); else passed++;
        total++; if (fields !== 32'h5678_1234) $display("FAIL basic_fields got=%h exp=56781234", fields); else passed++;
        total++; if (frame_cnt !== 8'd1) $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); else passed++;
        idle(1);
        total++; if (frame_valid !== 1'b0) $display("FAIL basic_pulse_end got=%b exp=0", frame_valid); else passed++;
        idle(4);
        total++; if (obs_err.size() !== 1) $display("FAIL basic_events got=%0d exp=1", obs_err.size()); else passed++;
    endtask

    task automatic test_broken_preamble();
        clear_obs();
        send_rep(8'hFF, 2);
        send_byte(8'h00, 0);
        send_rep(8'hFF, 4);
        send_payload4(8'h01, 8'h00, 8'h02, 8'h00, 0);
        idle(5);
        total++; if (fields !== 32'h0002_0001) $display("FAIL broken_fields got=%h exp=00020001", fields); else passed++;
        total++; if (obs_err.size() !== 1 || obs_err[0] !== 1'b0)
            $display("FAIL broken_events got=%0d exp=1 valid", obs_err.size()); else passed++;
        total++; if (frame_cnt !== 8'd2) $display("FAIL broken_frame_cnt got=%0d exp=2", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL broken_err_cnt got=%0d exp=0", err_cnt); else passed++;
    endtask

    task automatic test_extra_preamble();
        clear_obs();
        send_rep(8'hFF, 4);
        send_payload4(8'hFF, 8'hFF, 8'h0A, 8'h00, 0);
        send_byte(8'h0B, 0);
        send_byte(8'h00, 0);
        idle(TO + 10);
        total++; if (fields !== 32'h000A_FFFF) $display("FAIL extra_fields got=%h exp=000affff", fields); else passed++;
        total++; if (obs_err.size() !== 1 || obs_err[0] !== 1'b0)
            $display("FAIL extra_events got=%0d exp=1 valid", obs_err.size()); else passed++;
        total++; if (frame_cnt !== 8'd3) $display("FAIL extra_frame_cnt got=%0d exp=3", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL extra_err_cnt got=%0d exp=0", err_cnt); else passed++;
    endtask

    task automatic test_timeout();
        clear_obs();
        send_rep(8'hFF, 4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        for (int c = 1; c <= TO + 1; c++) begin
            idle(1);
            if (c == TO - 1) begin
                total++; if (frame_err !== 1'b0) $display("FAIL timeout_early got=%b exp=0 at idle %0d", frame_err, c); else passed++;
            end
            if (c == TO) begin
                total++; if (frame_err !== 1'b1) $display("FAIL timeout_pulse got=%b exp=1 at idle %0d", frame_err, c); else passed++;
            end
            if (c == TO + 1) begin
                total++; if (frame_err !== 1'b0) $display("FAIL timeout_pulse_end got=%b exp=0 at idle %0d", frame_err, c); else passed++;
            end
        end
        total++; if (err_cnt !== 8'd1) $display("FAIL timeout_err_cnt got=%0d exp=1", err_cnt); else passed++;
        total++; if (fields !== 32'h000A_FFFF) $display("FAIL timeout_fields got=%h exp=000affff", fields); else passed++;
        total++; if (frame_cnt !== 8'd3) $display("FAIL timeout_frame_cnt got=%0d exp=3", frame_cnt); else passed++;
    endtask

    task automatic test_gap_boundary();
        clear_obs();
        send_rep(8'hFF, 4);
        send_payload4(8'h01, 8'h02, 8'h03, 8'h04, TO - 1);
        idle(3);
        total++; if (obs_err.size() !== 1 || obs_err[0] !== 1'b0)
            $display("FAIL gap49_events got=%0d exp=1 valid", obs_err.size()); else passed++;
        total++; if (fields !== 32'h0403_0201) $display("FAIL gap49_fields got=%h exp=04030201", fields); else passed++;
        total++; if (frame_cnt !== 8'd4) $display("FAIL gap49_frame_cnt got=%0d exp=4", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL gap49_err_cnt got=%0d exp=1", err_cnt); else passed++;
    endtask

`ifdef UART_FRAME_CHECKSUM_EN
    task automatic test_checksum();
        clear_obs();
        send_rep(8'hFF, 4);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h04, 0);
        total++; if (frame_valid !== 1'b1) $display("FAIL ck_good_pulse got=%b exp=1", frame_valid); else passed++;
        send_rep(8'hFF, 4);
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
        send_byte(8'h0C, 0);
        total++; if (fields !== 32'h0807_0605) $display("FAIL ck_good_fields got=%h exp=08070605", fields); else passed++;
        send_rep(8'hFF, 4);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h05, 0);
        total++; if (frame_err !== 1'b1) $display("FAIL ck_bad_pulse got=%b exp=1", frame_err); else passed++;
        total++; if (fields !== 32'h0807_0605) $display("FAIL ck_bad_fields got=%h exp=08070605", fields); else passed++;
        total++; if (frame_cnt !== 8'd6) $display("FAIL ck_frame_cnt got=%0d exp=6", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd2) $display("FAIL ck_err_cnt got=%0d exp=2", err_cnt); else passed++;
    endtask
`endif

    task automatic test_reset_midframe();
        clear_obs();
        send_rep(8'hFF, 4);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (fields !== 32'h0) $display("FAIL midrst_fields got=%h exp=0", fields); else passed++;
        total++; if (frame_cnt !== 8'd0) $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); else passed++;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_byte(8'hCC, 0);
        send_rep(8'hFF, 4);
        send_payload4(8'h01, 8'h00, 8'h02, 8'h00, 0);
        idle(3);
        total++; if (fields !== 32'h0002_0001) $display("FAIL midrst_new_fields got=%h exp=00020001", fields); else passed++;
        total++; if (frame_cnt !== 8'd1) $display("FAIL midrst_new_frame_cnt got=%0d exp=1", frame_cnt); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL midrst_new_err_cnt got=%0d exp=0", err_cnt); else passed++;
    endtask

    task automatic test_random();
        logic [7:0] bytes[$];
        int         gaps[$];
        logic [7:0] x;
        logic [7:0] b;
        model_fields = 32'h0002_0001;
        exp_fc = 1;
        exp_ec = 0;
        for (int round = 0; round < 6; round++) begin
            bytes.delete();
            gaps.delete();
            exp_err.delete();
            exp_fields.delete();
            clear_obs();
            bytes.push_back(8'h00);
            for (int f = 0; f < 4; f++) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) bytes.push_back(8'($urandom_range(0, 255)));
                for (int j = 0; j < int'($urandom_range(PL - 1, PL + 2)); j++) bytes.push_back(8'hFF);
                x = 8'h00;
                for (int j = 0; j < FRAME_BYTES; j++) begin
                    b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                    x = x ^ b;
                    bytes.push_back(b);
                end
                if (CK != 0) bytes.push_back(($urandom_range(0, 4) == 0) ? (x ^ 8'h01) : x);
            end
            for (int i = 0; i < bytes.size(); i++) begin
                if (i != 0 && $urandom_range(0, 99) < 6) gaps.push_back(int'($urandom_range(TO - 2, TO + 2)));
                else gaps.push_back(int'($urandom_range(0, 4)));
            end
            model_stream(bytes, gaps, TO + 10);
            for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], gaps[i]);
            idle(TO + 10);
            total++;
            if (obs_err.size() !== exp_err.size())
                $display("FAIL rand%0d_event_count got=%0d exp=%0d", round, obs_err.size(), exp_err.size());
            else passed++;
            for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
                total++;
                if ({obs_err[i], obs_fields[i]} !== {exp_err[i], exp_fields[i]})
                    $display("FAIL rand%0d_event%0d got err=%b fields=%h exp err=%b fields=%h",
                             round, i, obs_err[i], obs_fields[i], exp_err[i], exp_fields[i]);
                else passed++;
            end
            total++; if (frame_cnt !== 8'(exp_fc)) $display("FAIL rand%0d_frame_cnt got=%0d exp=%0d", round, frame_cnt, exp_fc); else passed++;
            total++; if (err_cnt !== 8'(exp_ec)) $display("FAIL rand%0d_err_cnt got=%0d exp=%0d", round, err_cnt, exp_ec); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_broken_preamble();
        test_extra_preamble();
        test_timeout();
        test_gap_boundary();
`ifdef UART_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
